// File: rtl/edge_pkg.sv
// Shared types for the edge/level regeneration blocks.
package edge_pkg;

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} stretch_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter with a registered one-cycle overflow pulse.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         overflow_o
);

  localparam logic [W-1:0] MAX = {W{1'b1}};
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_q, count_d;
  logic         ovf_q, ovf_d;

  // Simultaneous inc and dec cancel; an inc at MAX is dropped and flagged.
  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    if (inc_i && !dec_i) begin
      if (count_q == MAX) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + ONE;
      end
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/edge_stretcher.sv
// Turns single-cycle trigger pulses into level phases of programmable width,
// separated by a programmable idle gap, with retrigger or queued re-launch.
module edge_stretcher
  import edge_pkg::*;
#(
  parameter int   CNT_W        = 8,
  parameter int   PEND_W       = 4,
  parameter logic INITIAL_DATA = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              trig_i,
  input  logic [CNT_W-1:0]  high_len_i,
  input  logic [CNT_W-1:0]  gap_len_i,
  input  logic              retrig_en_i,
  output logic              level_o,
  output logic              busy_o,
  output logic [PEND_W-1:0] pending_o,
  output logic              overflow_o
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  stretch_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             busy_q, busy_d;
  logic             pend_inc, pend_dec;
  logic             phase_done;
  logic [CNT_W-1:0] load_len;
  logic             launch_ok;

  assign load_len  = (high_len_i == '0) ? ONE : high_len_i;
  assign launch_ok = trig_i || (pending_o != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= INITIAL_DATA;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_inc   = 1'b0;
    pend_dec   = 1'b0;
    phase_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (launch_ok) begin
          state_d  = ACTIVE;
          cnt_d    = load_len;
          pend_dec = !trig_i;
        end
      end
      ACTIVE: begin
        if (trig_i && retrig_en_i) begin
          cnt_d = load_len;
        end else begin
          pend_inc = trig_i;
          if (cnt_q > ONE) begin
            cnt_d = cnt_q - ONE;
          end else if (gap_len_i != '0) begin
            state_d = GAP;
            cnt_d   = gap_len_i;
          end else begin
            phase_done = 1'b1;
          end
        end
      end
      GAP: begin
        pend_inc = trig_i;
        if (cnt_q > ONE) begin
          cnt_d = cnt_q - ONE;
        end else begin
          phase_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // End of gap (or zero-length gap): serve the next trigger, counting a
    // same-cycle trigger as the one consumed so pending nets out unchanged.
    if (phase_done) begin
      if (launch_ok) begin
        state_d  = ACTIVE;
        cnt_d    = load_len;
        pend_dec = 1'b1;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  always_comb begin
    level_d = (state_d == ACTIVE) ? ~INITIAL_DATA : INITIAL_DATA;
    busy_d  = (state_d != IDLE);
  end

  sat_counter #(
    .W (PEND_W)
  ) u_pending (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .inc_i      (pend_inc),
    .dec_i      (pend_dec),
    .count_o    (pending_o),
    .overflow_o (overflow_o)
  );

  assign level_o = level_q;
  assign busy_o  = busy_q;

endmodule
